// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the BCD display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Dash overrides blank, blank overrides the digit; nibbles above 9 show blank.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (!i_blank && (i_digit <= 4'd9)) begin
            o_seg = SEG_DIGITS[i_digit];
        end
    end

endmodule

// File: rtl/alu_bcd_display.sv
// Latches a 16-bit result, converts it to BCD with a serial double-dabble
// engine and scans the four low digits onto common-anode displays.
module alu_bcd_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 10000,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [15:0]       bcd,
    output logic [6:0]        seg,
    output logic [3:0]        an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_sreg;
    logic [19:0] r_acc;
    logic [19:0] w_adj;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic [15:0] r_bcd;

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [NUM_DIGITS-1:0] w_zero;
    logic [NUM_DIGITS-1:0] w_lz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (load) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == 4'd15) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                      (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_bcd  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_sreg <= value[15:0];
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    {r_acc, r_sreg} <= {w_adj[18:0], r_sreg, 1'b0};
                    r_cnt           <= r_cnt + 4'd1;
                end
                COMMIT: begin
                    r_bcd  <= r_acc[15:0];
                    r_ovf  <= (r_acc[19:16] != 4'd0);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A digit is blanked when it and every higher digit are zero; ones never blanks.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            assign w_zero[gi] = (r_bcd[4*gi +: 4] == 4'd0);
        end
        for (gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_lz
            assign w_lz[gi] = w_zero[gi] & w_lz[gi+1];
        end
    endgenerate
    assign w_lz[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
    assign w_lz[0]            = 1'b0;

    assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_blank = w_lz[r_idx];

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .i_dash  (r_ovf),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
            r_idx <= '0;
            r_an  <= 4'b1110;
            r_seg <= SEG_DIGITS[0];
        end else begin
            if (r_pre == PW'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_alu_bcd_display.sv
// Scoreboard bench for alu_bcd_display: directed and random loads, decimal
// reference model, per-cycle display/busy checks and done-pulse checks.
module tb_alu_bcd_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    alu_bcd_display #(.SCAN_DIV(SD), .DATA_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int v;
        int at_cyc;
    } ent_t;

    ent_t sb_q[$];
    ent_t cm_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int free_edge = 0;
    int acc_e = -100;
    int m_val = 0;
    bit m_ovf = 1'b0;

    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic int pow10(int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(int v, bit o, int idx);
        if (o) return 7'b0111111;
        if (idx > 0 && v < pow10(idx)) return 7'b1111111;
        return PAT[(v / pow10(idx)) % 10];
    endfunction

    function automatic int exp_bcd(int v);
        int r = 0;
        int w = v % 10000;
        for (int i = 0; i < 4; i++) r = r + (((w / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on done, plus per-cycle model comparisons.
    int         mc;
    int         pv;
    bit         po;
    int         idx;
    logic [3:0] ea;
    ent_t       me;

    always @(negedge clk) begin
        if (!rst) begin
            m_val = 0;
            m_ovf = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_bcd", bcd, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_an", an, 4'b1110);
            chk("rst_seg", seg, 7'b1000000);
        end else begin
            mc = cyc;
            pv = m_val;
            po = m_ovf;
            while (cm_q.size() > 0 && cm_q[0].at_cyc <= mc) begin
                me = cm_q.pop_front();
                m_val = me.v;
                m_ovf = (me.v > 9999);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done @cyc %0d: got done=1 expected done=0", mc);
                end else begin
                    me = sb_q.pop_front();
                    chk("done_latency", mc, me.at_cyc);
                    chk("done_bcd", bcd, exp_bcd(me.v));
                    chk("done_ovf", ovf, int'(me.v > 9999));
                    $display("txn value=%0d bcd=%h ovf=%0b at cyc %0d", me.v, bcd, ovf, mc);
                end
            end else if (sb_q.size() > 0 && sb_q[0].at_cyc < mc) begin
                me = sb_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_done @cyc %0d: got no done expected at cyc %0d for value %0d",
                         mc, me.at_cyc, me.v);
            end
            chk("busy", busy, int'(mc >= acc_e && mc < acc_e + 17));
            chk("bcd_hold", bcd, exp_bcd(m_val));
            chk("ovf_hold", ovf, int'(m_ovf));
            idx = (mc == 0) ? 0 : ((mc - 1) / SD) % 4;
            ea = ~(4'b0001 << idx);
            chk("an", an, ea);
            chk("seg", seg, exp_seg(pv % 10000, po, idx));
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(int v);
        ent_t e;
        load  = 1'b1;
        value = v[15:0];
        @(posedge clk);
        #1;
        if (cyc >= free_edge) begin
            acc_e     = cyc;
            free_edge = cyc + 18;
            e.v       = v;
            e.at_cyc  = cyc + 17;
            sb_q.push_back(e);
            cm_q.push_back(e);
            $display("load value=%0d accepted at cyc %0d", v, cyc);
        end else begin
            $display("load value=%0d dropped at cyc %0d (busy)", v, cyc);
        end
        #1;
        load = 1'b0;
    endtask

    task automatic apply_reset(int n);
        rst = 1'b0;
        sb_q.delete();
        cm_q.delete();
        free_edge = 0;
        acc_e     = -100;
        idle(n);
        rst = 1'b1;
    endtask

    int rv;
    int sel;

    initial begin
        load  = 1'b0;
        value = '0;
        rst   = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(20);

        do_load(1234);
        idle(35);
        do_load(65535);
        idle(35);
        do_load(7);
        idle(35);

        do_load(1234);
        idle(4);
        do_load(9999);
        idle(35);

        do_load(42);
        idle(20);
        do_load(777);
        idle(6);
        apply_reset(2);
        idle(2);
        do_load(777);
        idle(35);

        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      rv = $urandom_range(0, 9);
            else if (sel == 1) rv = $urandom_range(0, 9999);
            else               rv = $urandom_range(0, 65535);
            do_load(rv);
            idle($urandom_range(0, 22));
        end

        idle(40);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
